// File: rtl/g_3dbnc_n_pkg.sv
// Shared definitions for the three-channel active-low input conditioner:
// per-channel FSM state encoding and the legal parameter ranges.
package g_3dbnc_n_pkg;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_CNT  = 1'b1
  } db_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DB_CYCLES_MIN   = 1;
  localparam int DB_CYCLES_MAX   = 65535;

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/g_3dbnc_n_dbnc1.sv
// One conditioner channel: synchroniser chain, then a two-state debounce FSM
// that only follows the synchronised input after DB_CYCLES stable cycles.
module g_dbnc1
  import g_3dbnc_n_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic CK,
  input  logic CD,
  input  logic DIN_N,
  output logic DOUT_N,
  output logic CHG1
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   chg_q, chg_d;

  assign s      = sync_q[SYNC_STAGES-1];
  assign DOUT_N = out_q;
  assign CHG1   = chg_q;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      sync_q  <= '1;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], DIN_N};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (s != out_q) begin
          // A single-cycle filter has nothing to count: follow immediately.
          if (DB_CYCLES == 1) begin
            out_d = s;
          end else begin
            state_d = DB_CNT;
            cnt_d   = CW'(1);
          end
        end
      end
      DB_CNT: begin
        if (s == out_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          out_d   = s;
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    chg_d = (out_d != out_q);
  end

endmodule

// File: rtl/g_3dbnc_n.sv
// Three-channel active-low input conditioner feeding the g_3and3 decode stage:
// three independent debounce channels plus a merged one-cycle change pulse.
module g_3dbnc_n
  import g_3dbnc_n_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic CK,
  input  logic CD,
  input  logic AIN_N,
  input  logic BIN_N,
  input  logic CIN_N,
  output logic AN,
  output logic BN,
  output logic CN,
  output logic CHG
);

  generate
    if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_sync
      $error("g_3dbnc_n: SYNC_STAGES must be within 2..4");
    end
    if (!in_range(DB_CYCLES, DB_CYCLES_MIN, DB_CYCLES_MAX)) begin : g_bad_db
      $error("g_3dbnc_n: DB_CYCLES must be within 1..65535");
    end
  endgenerate

  logic chg_a, chg_b, chg_c;
  logic chg_q, chg_d;

  g_dbnc1 #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_dbnc_a (
    .CK(CK), .CD(CD), .DIN_N(AIN_N), .DOUT_N(AN), .CHG1(chg_a)
  );

  g_dbnc1 #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_dbnc_b (
    .CK(CK), .CD(CD), .DIN_N(BIN_N), .DOUT_N(BN), .CHG1(chg_b)
  );

  g_dbnc1 #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_dbnc_c (
    .CK(CK), .CD(CD), .DIN_N(CIN_N), .DOUT_N(CN), .CHG1(chg_c)
  );

  // Merging before the register keeps CHG a single pulse when channels change together.
  assign chg_d = chg_a | chg_b | chg_c;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) chg_q <= 1'b0;
    else    chg_q <= chg_d;
  end

  assign CHG = chg_q;

endmodule

// File: tb/tb_g_3dbnc_n.sv
// Directed and randomized bench for g_3dbnc_n with default and single-cycle debounce.
module tb_g_3dbnc_n;

  localparam int SS   = 2;
  localparam int HMAX = 8192;

  logic CK = 1'b0;
  logic CD, AIN_N, BIN_N, CIN_N;
  logic AN, BN, CN, CHG;
  logic AN1, BN1, CN1, CHG1;

  int tests = 0;
  int fails = 0;

  always #5 CK = ~CK;

  g_3dbnc_n #(.SYNC_STAGES(SS), .DB_CYCLES(4)) dut (
    .CK(CK), .CD(CD), .AIN_N(AIN_N), .BIN_N(BIN_N), .CIN_N(CIN_N),
    .AN(AN), .BN(BN), .CN(CN), .CHG(CHG)
  );

  g_3dbnc_n #(.SYNC_STAGES(SS), .DB_CYCLES(1)) dut1 (
    .CK(CK), .CD(CD), .AIN_N(AIN_N), .BIN_N(BIN_N), .CIN_N(CIN_N),
    .AN(AN1), .BN(BN1), .CN(CN1), .CHG(CHG1)
  );

  // Reference model: raw input history since reset; an output flips when the
  // synchronised value has differed from it for DB consecutive edges.
  logic rawh[3][HMAX];
  int   n_edges;
  int   dbv[2] = '{4, 1};
  logic mo[2][3];
  logic chg_exp[2];
  logic flip_prev[2];

  function automatic logic s_at(input int c, input int n);
    if (n - SS >= 1) return rawh[c][n-SS];
    return 1'b1;
  endfunction

  task automatic model_reset();
    n_edges = 0;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) mo[d][c] = 1'b1;
      chg_exp[d]   = 1'b0;
      flip_prev[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic anyflip, flip;
    if (CD) begin
      model_reset();
    end else begin
      n_edges++;
      rawh[0][n_edges] = AIN_N;
      rawh[1][n_edges] = BIN_N;
      rawh[2][n_edges] = CIN_N;
      for (int d = 0; d < 2; d++) begin
        anyflip = 1'b0;
        for (int c = 0; c < 3; c++) begin
          flip = 1'b1;
          for (int j = 0; j < dbv[d]; j++)
            if (n_edges - j < 1 || s_at(c, n_edges - j) == mo[d][c]) flip = 1'b0;
          if (flip) begin
            mo[d][c] = ~mo[d][c];
            anyflip  = 1'b1;
          end
        end
        chg_exp[d]   = flip_prev[d];
        flip_prev[d] = anyflip;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("AN",   {31'd0, AN},   {31'd0, mo[0][0]});
    chk("BN",   {31'd0, BN},   {31'd0, mo[0][1]});
    chk("CN",   {31'd0, CN},   {31'd0, mo[0][2]});
    chk("CHG",  {31'd0, CHG},  {31'd0, chg_exp[0]});
    chk("AN1",  {31'd0, AN1},  {31'd0, mo[1][0]});
    chk("BN1",  {31'd0, BN1},  {31'd0, mo[1][1]});
    chk("CN1",  {31'd0, CN1},  {31'd0, mo[1][2]});
    chk("CHG1", {31'd0, CHG1}, {31'd0, chg_exp[1]});
  endtask

  task automatic step();
    @(posedge CK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic assert_reset();
    CD = 1'b1;
    #1;
    model_reset();
    check_all();
  endtask

  function automatic logic out_of(input int d, input int c);
    if (d == 0) return (c == 0) ? AN : (c == 1) ? BN : CN;
    return (c == 0) ? AN1 : (c == 1) ? BN1 : CN1;
  endfunction

  task automatic measure(input int c, input logic tgt, output int lat0, output int lat1);
    lat0 = 0;
    lat1 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (lat0 == 0 && out_of(0, c) === tgt) lat0 = k;
      if (lat1 == 0 && out_of(1, c) === tgt) lat1 = k;
    end
  endtask

  int l0, l1;

  initial begin
    CD = 1'b0; AIN_N = 1'b1; BIN_N = 1'b1; CIN_N = 1'b1;
    #1;
    CD = 1'b1;
    #1;
    model_reset();
    check_all();

    // Inputs toggling while held in reset must not reach the outputs.
    for (int i = 0; i < 4; i++) begin
      AIN_N = ~AIN_N; BIN_N = ~BIN_N; CIN_N = ~CIN_N;
      step();
    end
    AIN_N = 1'b1; BIN_N = 1'b1; CIN_N = 1'b1;
    step();
    CD = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Clean assert and release on channel A.
    AIN_N = 1'b0;
    measure(0, 1'b0, l0, l1);
    chk("lat_assert_db4", l0, 6);
    chk("lat_assert_db1", l1, 3);
    AIN_N = 1'b1;
    measure(0, 1'b1, l0, l1);
    chk("lat_release_db4", l0, 6);
    chk("lat_release_db1", l1, 3);

    // Three-cycle glitch on channel B.
    BIN_N = 1'b0;
    for (int i = 0; i < 3; i++) step();
    BIN_N = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Simultaneous change on all channels, then reset while asserted.
    AIN_N = 1'b0; BIN_N = 1'b0; CIN_N = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("all_low_AN", {31'd0, AN}, 32'd0);
    assert_reset();
    step();
    CD = 1'b0;
    AIN_N = 1'b1; BIN_N = 1'b1; CIN_N = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-count on channel C, input kept low across the reset.
    CIN_N = 1'b0;
    for (int i = 0; i < 4; i++) step();
    assert_reset();
    step();
    CD = 1'b0;
    measure(2, 1'b0, l0, l1);
    chk("lat_after_reset_db4", l0, 6);
    chk("lat_after_reset_db1", l1, 3);
    CIN_N = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Randomized bouncing inputs with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) AIN_N = ~AIN_N;
      if ($urandom_range(0, 4) == 0) BIN_N = ~BIN_N;
      if ($urandom_range(0, 5) == 0) CIN_N = ~CIN_N;
      if ($urandom_range(0, 149) == 0) begin
        assert_reset();
        step();
        CD = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
